// File: rtl/segment_driver_n.sv
// Walks a single lit segment across NUM_SEGMENTS outputs. The walk is either
// manual (step pulses) or automatic (built-in step-rate counter). Mode
// requests and step requests are single-cycle pulses from the edge detector.
//
// mode       | meaning
// -----------+-------------------------------------------------------------
// M_FORWARD  | manual, next_segment_re moves position up with wrap
// M_BACKWARD | manual, next_segment_re moves position down with wrap
// M_OFF      | display blank, position and direction frozen
// M_CYCLIC   | automatic, one step up (with wrap) every TICK_PERIOD cycles
// M_BOUNCE   | automatic, ping-pongs between 0 and N-1 every TICK_PERIOD
module segment_driver_n #(
    parameter int NUM_SEGMENTS  = 6,
    parameter int DISPLAY_WIDTH = 8,
    parameter int TICK_PERIOD   = 50000000,
    localparam int POS_W = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1,
    localparam int CNT_W = $clog2(TICK_PERIOD)
) (
    input  logic                     clk,
    input  logic                     async_nreset,
    input  logic                     next_segment_re,
    input  logic                     change_mode_re,
    output logic [DISPLAY_WIDTH-1:0] display,
    output logic [2:0]               mode,
    output logic [POS_W-1:0]         position,
    output logic                     step_pulse
);

    typedef enum logic [2:0] {
        M_FORWARD  = 3'd0,
        M_BACKWARD = 3'd1,
        M_OFF      = 3'd2,
        M_CYCLIC   = 3'd3,
        M_BOUNCE   = 3'd4
    } mode_t;

    // Wrap points are the last real segment, never 2^POS_W-1.
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_SEGMENTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD - 1);

    mode_t            mode_q, mode_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] pos_inc, pos_dec;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_pulse_q;
    logic             auto_mode;
    logic             tick;

    assign pos_inc   = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    assign pos_dec   = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
    assign auto_mode = (mode_q == M_CYCLIC) || (mode_q == M_BOUNCE);
    assign tick      = auto_mode && (cnt_q == CNT_LAST);

    // Next-state: step is judged under the current mode, then a mode request
    // (if any) overrides the mode and restarts the step-rate counter.
    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        cnt_d    = (!auto_mode || tick) ? '0 : cnt_q + CNT_W'(1);

        case (mode_q)
            M_FORWARD:  if (next_segment_re) pos_d = pos_inc;
            M_BACKWARD: if (next_segment_re) pos_d = pos_dec;
            M_OFF:      ;
            M_CYCLIC:   if (tick) pos_d = pos_inc;
            M_BOUNCE: begin
                if (tick) begin
                    if (dir_up_q) begin
                        if (pos_q == POS_LAST) begin
                            pos_d    = pos_dec;
                            dir_up_d = 1'b0;
                        end else begin
                            pos_d = pos_inc;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d    = pos_inc;
                            dir_up_d = 1'b1;
                        end else begin
                            pos_d = pos_dec;
                        end
                    end
                end
            end
            default:    mode_d = M_FORWARD;
        endcase

        if (change_mode_re) begin
            cnt_d = '0;
            case (mode_q)
                M_FORWARD:  mode_d = M_BACKWARD;
                M_BACKWARD: mode_d = M_OFF;
                M_OFF:      mode_d = M_CYCLIC;
                M_CYCLIC:   mode_d = M_BOUNCE;
                default:    mode_d = M_FORWARD;
            endcase
            if (mode_d == M_BOUNCE) dir_up_d = 1'b1;
        end
    end

    // State register; step_pulse marks the first cycle a new position shows.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            mode_q       <= M_FORWARD;
            pos_q        <= '0;
            dir_up_q     <= 1'b1;
            cnt_q        <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            pos_q        <= pos_d;
            dir_up_q     <= dir_up_d;
            cnt_q        <= cnt_d;
            step_pulse_q <= (pos_d != pos_q);
        end
    end

    assign display    = (mode_q == M_OFF) ? '0 : (DISPLAY_WIDTH'(1) << pos_q);
    assign mode       = mode_q;
    assign position   = pos_q;
    assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_segment_driver_n.sv
// Bench for segment_driver_n: three instances (N = 6, 5, 2, tick period 4)
// share one stimulus stream and are compared every cycle against a model
// built from modular arithmetic and a triangular-wave phase for BOUNCE.
module tb_segment_driver_n;

    localparam int T = 4;

    logic clk = 1'b0;
    logic async_nreset = 1'b0;
    logic next_segment_re = 1'b0;
    logic change_mode_re = 1'b0;

    logic [7:0] disp6, disp5, disp2;
    logic [2:0] mode6, mode5, mode2;
    logic [2:0] pos6, pos5;
    logic [0:0] pos2;
    logic       sp6, sp5, sp2;

    int n_chk = 0;
    int n_fail = 0;

    int nseg [3] = '{6, 5, 2};
    int m_mode [3];
    int m_pos [3];
    int m_ph [3];
    int m_el [3];
    bit m_sp [3];

    always #5 clk = ~clk;

    segment_driver_n #(.NUM_SEGMENTS(6), .DISPLAY_WIDTH(8), .TICK_PERIOD(T)) u_n6 (
        .clk(clk), .async_nreset(async_nreset), .next_segment_re(next_segment_re),
        .change_mode_re(change_mode_re), .display(disp6), .mode(mode6),
        .position(pos6), .step_pulse(sp6));

    segment_driver_n #(.NUM_SEGMENTS(5), .DISPLAY_WIDTH(8), .TICK_PERIOD(T)) u_n5 (
        .clk(clk), .async_nreset(async_nreset), .next_segment_re(next_segment_re),
        .change_mode_re(change_mode_re), .display(disp5), .mode(mode5),
        .position(pos5), .step_pulse(sp5));

    segment_driver_n #(.NUM_SEGMENTS(2), .DISPLAY_WIDTH(8), .TICK_PERIOD(T)) u_n2 (
        .clk(clk), .async_nreset(async_nreset), .next_segment_re(next_segment_re),
        .change_mode_re(change_mode_re), .display(disp2), .mode(mode2),
        .position(pos2), .step_pulse(sp2));

    function automatic logic [15:0] obs(input int i);
        case (i)
            0:       return {disp6, mode6, 1'b0, pos6, sp6};
            1:       return {disp5, mode5, 1'b0, pos5, sp5};
            default: return {disp2, mode2, 3'b000, pos2, sp2};
        endcase
    endfunction

    function automatic logic [15:0] expv(input int i);
        logic [7:0] d;
        d = (m_mode[i] == 2) ? 8'h00 : 8'(1 << m_pos[i]);
        return {d, 3'(m_mode[i]), 4'(m_pos[i]), m_sp[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_pos[i] = 0; m_ph[i] = 0; m_el[i] = 0; m_sp[i] = 0;
        end
    endtask

    // One rising edge of the reference behaviour for every instance.
    task automatic model_edge(input bit n, input bit c);
        int old_pos, nn;
        for (int i = 0; i < 3; i++) begin
            nn = nseg[i];
            old_pos = m_pos[i];
            case (m_mode[i])
                0: if (n) m_pos[i] = (m_pos[i] + 1) % nn;
                1: if (n) m_pos[i] = (m_pos[i] + nn - 1) % nn;
                3, 4: begin
                    if ((m_el[i] + 1) % T == 0) begin
                        if (m_mode[i] == 3) m_pos[i] = (m_pos[i] + 1) % nn;
                        else begin
                            m_ph[i] = (m_ph[i] + 1) % (2 * nn - 2);
                            m_pos[i] = (m_ph[i] < nn) ? m_ph[i] : 2 * nn - 2 - m_ph[i];
                        end
                    end
                    m_el[i]++;
                end
                default: ;
            endcase
            if (c) begin
                m_mode[i] = (m_mode[i] + 1) % 5;
                m_el[i] = 0;
                if (m_mode[i] == 4) m_ph[i] = m_pos[i];
            end
            m_sp[i] = (m_pos[i] != old_pos);
        end
    endtask

    task automatic cycle(input bit n, input bit c);
        next_segment_re = n;
        change_mode_re = c;
        @(posedge clk);
        model_edge(n, c);
        #1;
        next_segment_re = 1'b0;
        change_mode_re = 1'b0;
    endtask

    task automatic do_reset();
        async_nreset = 1'b0;
        model_reset();
        #3;
        async_nreset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs(i) !== 16'h0100) begin
                n_fail++;
                $display("FAIL reset inst%0d got=%h want=%h", i, obs(i), 16'h0100);
            end
        end
    endtask

    task automatic test_forward();
        for (int s = 0; s < 7; s++) begin
            for (int ph = 0; ph < 2; ph++) begin
                cycle(ph == 0, 1'b0);
                for (int i = 0; i < 3; i++) begin
                    n_chk++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL forward inst%0d step%0d got=%h want=%h", i, s, obs(i), expv(i));
                    end
                end
            end
        end
        n_chk++;
        if (disp6 !== 8'h02) begin
            n_fail++;
            $display("FAIL forward_end_display got=%h want=%h", disp6, 8'h02);
        end
    endtask

    task automatic test_backward();
        do_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        n_chk++;
        if (pos6 !== 3'd5) begin
            n_fail++;
            $display("FAIL backward_wrap got=%0d want=5", pos6);
        end
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs(i) !== expv(i)) begin
                n_fail++;
                $display("FAIL backward inst%0d got=%h want=%h", i, obs(i), expv(i));
            end
        end
        n_chk++;
        if (disp6 !== 8'h10) begin
            n_fail++;
            $display("FAIL backward_display got=%h want=%h", disp6, 8'h10);
        end
    endtask

    task automatic test_off_cyclic();
        int first;
        cycle(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL off inst%0d got=%h want=%h", i, obs(i), expv(i));
                end
            end
        end
        n_chk++;
        if (disp6 !== 8'h00) begin
            n_fail++;
            $display("FAIL off_display got=%h want=%h", disp6, 8'h00);
        end
        cycle(1'b0, 1'b1);
        first = 0;
        for (int k = 1; k <= 14; k++) begin
            cycle(1'b0, 1'b0);
            if (sp6 === 1'b1 && first == 0) first = k;
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL cyclic inst%0d cyc%0d got=%h want=%h", i, k, obs(i), expv(i));
                end
            end
        end
        n_chk++;
        if (first != T) begin
            n_fail++;
            $display("FAIL cyclic_first_step got=%0d want=%0d", first, T);
        end
    endtask

    task automatic test_bounce();
        int exp_seq [8] = '{4, 5, 4, 3, 2, 1, 0, 1};
        int got, last, k;
        bit found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            cycle(1'b0, 1'b0);
            if (m_pos[0] == 3 && m_sp[0]) found = 1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL bounce_setup got=%0d want=3", pos6);
        end
        cycle(1'b0, 1'b1);
        got = 0; last = 0; k = 0;
        while (got < 8 && k < 50) begin
            k++;
            cycle(1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL bounce inst%0d cyc%0d got=%h want=%h", i, k, obs(i), expv(i));
                end
            end
            if (sp6 === 1'b1) begin
                n_chk++;
                if (int'(pos6) != exp_seq[got] || k - last != T) begin
                    n_fail++;
                    $display("FAIL bounce_seq step%0d got=%0d/%0d want=%0d/%0d",
                             got, pos6, k - last, exp_seq[got], T);
                end
                last = k;
                got++;
            end
        end
        n_chk++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL bounce_steps got=%0d want=8", got);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        n_chk++;
        if (pos6 !== 3'd3 || mode6 !== 3'd1) begin
            n_fail++;
            $display("FAIL simultaneous got=pos%0d/mode%0d want=pos3/mode1", pos6, mode6);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs(i) !== expv(i)) begin
                n_fail++;
                $display("FAIL simultaneous inst%0d got=%h want=%h", i, obs(i), expv(i));
            end
        end
    endtask

    task automatic test_random();
        bit n, c;
        for (int k = 0; k < 400; k++) begin
            n = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 15) == 0);
            cycle(n, c);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d got=%h want=%h", i, k, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
        n_chk++;
        if (mode6 !== 3'd4 || pos6 === 3'd0) begin
            n_fail++;
            $display("FAIL async_setup got=mode%0d/pos%0d want=mode4/pos!=0", mode6, pos6);
        end
        async_nreset = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs(i) !== 16'h0100) begin
                n_fail++;
                $display("FAIL async_reset inst%0d got=%h want=%h", i, obs(i), 16'h0100);
            end
        end
        #2;
        async_nreset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL after_reset inst%0d got=%h want=%h", i, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_forward();
        test_backward();
        test_off_cyclic();
        test_bounce();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
